// File: rtl/bar_pkg.sv
// rtl/bar_pkg.sv - shared bar-graph constants, state enum and height saturation helper
package bar_pkg;

    localparam int SCREEN_H  = 480;
    localparam int H_W       = 10;
    localparam int NUM_BARS  = 10;
    localparam int BAR_WIDTH = 53;
    localparam int BAR_GAP   = 10;

    typedef enum logic {
        ACCUM  = 1'b0,
        COMMIT = 1'b1
    } state_t;

    // Clamp a scaled magnitude to the height limit; lim must fit in H_W bits.
    function automatic logic [H_W-1:0] sat_height(input logic [31:0] v, input logic [31:0] lim);
        if (v > lim) begin
            return lim[H_W-1:0];
        end
        return v[H_W-1:0];
    endfunction

endpackage

// File: rtl/bar_cell.sv
// rtl/bar_cell.sv - one bar: committed target, attack/decay height and BarY register
module bar_cell
    import bar_pkg::*;
#(
    parameter int DECAY_STEP = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           commit,
    input  logic [H_W-1:0] new_target,
    input  logic           frame_clk,
    output logic [H_W-1:0] bar_y
);

    localparam logic [H_W-1:0] STEP   = H_W'(DECAY_STEP);
    localparam logic [H_W-1:0] TOP_Y  = H_W'(SCREEN_H);

    logic [H_W-1:0] target;
    logic [H_W-1:0] h;
    logic [H_W-1:0] next_h;
    logic [H_W-1:0] decayed;

    // Instant attack to a higher target, otherwise fall by STEP but never below target or zero.
    always_comb begin
        decayed = '0;
        next_h  = target;
        if (target <= h) begin
            decayed = (h >= STEP) ? (h - STEP) : '0;
            next_h  = (decayed > target) ? decayed : target;
        end
    end

    // Target register persists until the next spectrum commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target <= '0;
        end else if (commit) begin
            target <= new_target;
        end
    end

    // Height and its screen row move only on the frame pulse, so a same-cycle commit is seen next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h     <= '0;
            bar_y <= TOP_Y;
        end else if (frame_clk) begin
            h     <= next_h;
            bar_y <= TOP_Y - next_h;
        end
    end

endmodule

// File: rtl/bar_height_gen.sv
// rtl/bar_height_gen.sv - folds an FFT magnitude stream into smoothed per-bar top rows
module bar_height_gen
    import bar_pkg::*;
#(
    parameter int NUM_BARS     = bar_pkg::NUM_BARS,
    parameter int BINS_PER_BAR = 4,
    parameter int MAG_W        = 16,
    parameter int SHIFT        = 6,
    parameter int MAX_H        = 470,
    parameter int DECAY_STEP   = 4
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    Mag_valid,
    input  logic [MAG_W-1:0]        Mag_data,
    input  logic                    Mag_last,
    output logic                    Mag_ready,
    input  logic                    Frame_clk,
    output logic [NUM_BARS*H_W-1:0] BarY,
    output logic                    Frame_done
);

    localparam int BIN_W = (BINS_PER_BAR > 1) ? $clog2(BINS_PER_BAR) : 1;
    localparam int IDX_W = $clog2(NUM_BARS + 1);
    localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(BINS_PER_BAR - 1);
    localparam logic [IDX_W-1:0] IDX_OVF  = IDX_W'(NUM_BARS);

    state_t              state;
    logic [BIN_W-1:0]    bin_cnt;
    logic [IDX_W-1:0]    bar_idx;
    logic [MAG_W-1:0]    work [NUM_BARS];
    logic [NUM_BARS-1:0] touched;
    logic                xfer;
    logic                commit;

    assign xfer   = Mag_valid && Mag_ready;
    assign commit = (state == COMMIT);

    // Sequencer: walk bins and bars in ACCUM, spend one non-ready cycle in COMMIT after the last sample.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ACCUM;
            Mag_ready <= 1'b1;
            bin_cnt   <= '0;
            bar_idx   <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (xfer) begin
                        if (Mag_last) begin
                            state     <= COMMIT;
                            Mag_ready <= 1'b0;
                        end else if (bar_idx != IDX_OVF) begin
                            if (bin_cnt == BIN_LAST) begin
                                bin_cnt <= '0;
                                bar_idx <= bar_idx + 1'b1;
                            end else begin
                                bin_cnt <= bin_cnt + 1'b1;
                            end
                        end
                    end
                end
                COMMIT: begin
                    state     <= ACCUM;
                    Mag_ready <= 1'b1;
                    bin_cnt   <= '0;
                    bar_idx   <= '0;
                end
                default: begin
                    state     <= ACCUM;
                    Mag_ready <= 1'b1;
                end
            endcase
        end
    end

    // Running peak per bar; the first bin of a bar overwrites whatever the previous spectrum left.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                work[i] <= '0;
            end
            touched <= '0;
        end else if (commit) begin
            touched <= '0;
        end else if (xfer && (bar_idx != IDX_OVF)) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                if (bar_idx == IDX_W'(i)) begin
                    if ((bin_cnt == '0) || (Mag_data > work[i])) begin
                        work[i] <= Mag_data;
                    end
                    touched[i] <= 1'b1;
                end
            end
        end
    end

    // Frame_done marks the cycle the bar cells present their new rows.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Frame_done <= 1'b0;
        end else begin
            Frame_done <= Frame_clk;
        end
    end

    for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
        logic [H_W-1:0] new_target;

        assign new_target = touched[g] ? sat_height(32'(work[g] >> SHIFT), 32'(MAX_H)) : '0;

        bar_cell #(
            .DECAY_STEP(DECAY_STEP)
        ) u_cell (
            .clk        (Clk),
            .rst_n      (Reset_n),
            .commit     (commit),
            .new_target (new_target),
            .frame_clk  (Frame_clk),
            .bar_y      (BarY[g*H_W +: H_W])
        );
    end

endmodule
